// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM frame arbiter: default widths, FSM states
// and transfer-direction encoding.
package sram_pkg;

  localparam int ADDR_W_DEF        = 20;
  localparam int DATA_W_DEF        = 16;
  localparam int RD_LAT_DEF        = 2;
  localparam int WR_STARVE_MAX_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    TURN = 2'd3
  } arb_state_e;

  typedef enum logic {
    DIR_RD = 1'b0,
    DIR_WR = 1'b1
  } dir_e;

endpackage

// File: rtl/sram_rd_latency_pipe.sv
// Read-tag shift register matching the SRAM wrapper latency, plus the
// response capture register. RD_LAT must be at least 1.
module sram_rd_latency_pipe
  import sram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tag_in,
  input  logic [DATA_W-1:0] sram_dout,
  output logic              rd_resp_valid,
  output logic [DATA_W-1:0] rd_resp_data
);

  logic [RD_LAT:0] tag_p0;

  // Tag stage: one bit per cycle of flight, tail marks data present on sram_dout
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_p0 <= '0;
    end else begin
      tag_p0 <= {tag_p0[RD_LAT-1:0], tag_in};
    end
  end

  // Response stage: capture wrapper data when the tag reaches the tail
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_resp_valid <= 1'b0;
      rd_resp_data  <= '0;
    end else begin
      rd_resp_valid <= tag_p0[RD_LAT];
      if (tag_p0[RD_LAT]) begin
        rd_resp_data <= sram_dout;
      end
    end
  end

endmodule

// File: rtl/sram_frame_arbiter.sv
// Sole master of the SRAM wrapper: arbitrates pixel writes against display
// reads, inserts a turnaround on direction changes and returns read data.
module sram_frame_arbiter
  import sram_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int RD_LAT        = RD_LAT_DEF,
  parameter int WR_STARVE_MAX = WR_STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_resp_valid,
  output logic [DATA_W-1:0] rd_resp_data,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout
);

  localparam int CNT_W = $clog2(WR_STARVE_MAX + 1);

  arb_state_e       state, state_nxt;
  dir_e             last_dir, win_dir;
  logic [CNT_W-1:0] starve_cnt;
  logic             starved, rd_win, wr_win, prev_issued, need_turn;
  logic             rd_grant, wr_grant;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_W'(WR_STARVE_MAX)) ? v : v + 1'b1;
  endfunction

  // Reads win unless a write has lost WR_STARVE_MAX cycles in a row
  assign starved     = (starve_cnt == CNT_W'(WR_STARVE_MAX));
  assign rd_win      = rd_valid && !(wr_valid && starved);
  assign wr_win      = wr_valid && !rd_win;
  assign win_dir     = rd_win ? DIR_RD : DIR_WR;
  assign prev_issued = (state == RD) || (state == WR);
  assign need_turn   = (rd_win || wr_win) && prev_issued && (win_dir != last_dir);

  always_comb begin
    state_nxt = IDLE;
    rd_grant  = 1'b0;
    wr_grant  = 1'b0;
    if (need_turn) begin
      state_nxt = TURN;
    end else if (rd_win) begin
      state_nxt = RD;
      rd_grant  = 1'b1;
    end else if (wr_win) begin
      state_nxt = WR;
      wr_grant  = 1'b1;
    end
  end

  assign rd_ready = rd_grant && !reset;
  assign wr_ready = wr_grant && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_dir   <= DIR_RD;
      starve_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (rd_grant) begin
        last_dir <= DIR_RD;
      end else if (wr_grant) begin
        last_dir <= DIR_WR;
      end
      if (!wr_valid || wr_grant) begin
        starve_cnt <= '0;
      end else begin
        starve_cnt <= sat_inc(starve_cnt);
      end
    end
  end

  // Issue stage: granted transfer appears on the wrapper bus one cycle after accept
  always_ff @(posedge clk) begin
    if (reset) begin
      sram_wen  <= 1'b0;
      sram_addr <= '0;
      sram_din  <= '0;
    end else begin
      sram_wen <= wr_grant;
      if (wr_grant) begin
        sram_addr <= wr_addr;
        sram_din  <= wr_data;
      end else if (rd_grant) begin
        sram_addr <= rd_addr;
      end
    end
  end

  sram_rd_latency_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk           (clk),
    .reset         (reset),
    .tag_in        (rd_grant),
    .sram_dout     (sram_dout),
    .rd_resp_valid (rd_resp_valid),
    .rd_resp_data  (rd_resp_data)
  );

endmodule

// File: tb/tb_sram_frame_arbiter.sv
// Scoreboard bench for sram_frame_arbiter with a behavioural SRAM wrapper.
module tb_sram_frame_arbiter;

  localparam int ADDR_W        = 20;
  localparam int DATA_W        = 16;
  localparam int RD_LAT        = 2;
  localparam int WR_STARVE_MAX = 8;
  localparam int BOUND         = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wr_valid = 1'b0, rd_valid = 1'b0;
  logic              wr_ready, rd_ready;
  logic [ADDR_W-1:0] wr_addr = '0, rd_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd_resp_valid;
  logic [DATA_W-1:0] rd_resp_data;
  logic              sram_wen;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_din;
  logic [DATA_W-1:0] sram_dout;

  always #5 clk = ~clk;

  sram_frame_arbiter #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .RD_LAT        (RD_LAT),
    .WR_STARVE_MAX (WR_STARVE_MAX)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_addr       (rd_addr),
    .rd_resp_valid (rd_resp_valid),
    .rd_resp_data  (rd_resp_data),
    .sram_wen      (sram_wen),
    .sram_addr     (sram_addr),
    .sram_din      (sram_din),
    .sram_dout     (sram_dout)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
    return a[DATA_W-1:0] ^ 16'hC3C3;
  endfunction

  // Behavioural wrapper: address sampled each edge, data valid RD_LAT edges later
  logic [DATA_W-1:0] smem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] dpipe [RD_LAT];

  always @(posedge clk) begin
    dpipe[0] <= smem.exists(sram_addr) ? smem[sram_addr] : init_val(sram_addr);
    for (int i = 1; i < RD_LAT; i++) dpipe[i] <= dpipe[i-1];
    if (sram_wen === 1'b1) smem[sram_addr] = sram_din;
  end
  assign sram_dout = dpipe[RD_LAT-1];

  // Reference contents and scoreboards
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              wen;
    int                due;
  } iss_t;
  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } rsp_t;

  logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];
  iss_t iss_q[$];
  rsp_t rsp_q[$];

  function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  always @(negedge clk) begin
    iss_t ie;
    rsp_t re;
    if (reset) check_eq("rdy_in_reset", 64'({wr_ready, rd_ready}), 64'd0);
    if (wr_ready && rd_ready) check_eq("dual_grant", 64'(wr_ready & rd_ready), 64'd0);

    if (iss_q.size() != 0 && iss_q[0].due == cyc) begin
      ie = iss_q.pop_front();
      check_eq("iss_wen", 64'(sram_wen), 64'(ie.wen));
      check_eq("iss_addr", 64'(sram_addr), 64'(ie.addr));
      if (ie.wen) check_eq("iss_din", 64'(sram_din), 64'(ie.data));
    end else if (sram_wen === 1'b1) begin
      check_eq("iss_spurious", 64'(sram_wen), 64'd0);
    end

    if (rsp_q.size() != 0 && rsp_q[0].due == cyc) begin
      re = rsp_q.pop_front();
      check_eq("rsp_valid", 64'(rd_resp_valid), 64'd1);
      check_eq("rsp_data", 64'(rd_resp_data), 64'(re.data));
    end else if (rd_resp_valid === 1'b1) begin
      check_eq("rsp_spurious", 64'(rd_resp_valid), 64'd0);
    end

    if (!reset && wr_valid && wr_ready) begin
      ref_mem[wr_addr] = wr_data;
      iss_q.push_back('{wr_addr, wr_data, 1'b1, cyc + 1});
    end
    if (!reset && rd_valid && rd_ready) begin
      iss_q.push_back('{rd_addr, '0, 1'b0, cyc + 1});
      rsp_q.push_back('{ref_rd(rd_addr), cyc + RD_LAT + 2});
    end
    if (reset) begin
      iss_q.delete();
      rsp_q.delete();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_req(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int n = 0;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    #1;
    while (!wr_ready && n < BOUND) begin
      @(posedge clk);
      #2;
      n++;
    end
    check_eq("wr_grant", 64'(wr_ready), 64'd1);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((rsp_q.size() != 0 || iss_q.size() != 0) && n < BOUND) begin
      tick();
      n++;
    end
    check_eq("drain", 64'(rsp_q.size() + iss_q.size()), 64'd0);
    tick();
    tick();
  endtask

  initial begin
    int r;
    // Reset with both requests asserted
    wr_valid = 1'b1;
    rd_valid = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #2;
      check_eq("reset_outs", 64'({sram_wen, sram_addr, sram_din, rd_resp_valid,
                                  rd_resp_data, wr_ready, rd_ready}), 64'd0);
    end
    reset    = 1'b0;
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    tick();

    // Single write, idle gap, read back
    wr_req(20'h00010, 16'hBEEF);
    tick();
    rd_valid = 1'b1;
    rd_addr  = 20'h00010;
    #1;
    check_eq("rd_after_idle", 64'(rd_ready), 64'd1);
    tick();
    rd_valid = 1'b0;
    drain();

    // Sixteen back-to-back reads
    for (int i = 0; i < 16; i++) begin
      rd_valid = 1'b1;
      rd_addr  = ADDR_W'(i);
      #1;
      check_eq("b2b_rd_ready", 64'(rd_ready), 64'd1);
      tick();
    end
    rd_valid = 1'b0;
    drain();

    // Write then immediate read: one turnaround cycle
    wr_valid = 1'b1;
    wr_addr  = 20'h00020;
    wr_data  = 16'h1234;
    #1;
    check_eq("turn_wr_grant", 64'(wr_ready), 64'd1);
    tick();
    wr_valid = 1'b0;
    rd_valid = 1'b1;
    rd_addr  = 20'h00020;
    #1;
    check_eq("turn_rd_blocked", 64'(rd_ready), 64'd0);
    tick();
    #1;
    check_eq("turn_rd_grant", 64'(rd_ready), 64'd1);
    tick();
    rd_valid = 1'b0;
    drain();

    // Write starvation under continuous reads
    r = 0;
    for (int k = 0; k < 12; k++) begin
      wr_valid = (k <= 9);
      wr_addr  = 20'h00030;
      wr_data  = 16'h5A5A;
      rd_valid = 1'b1;
      rd_addr  = ADDR_W'(256 + r);
      #1;
      check_eq("starve_rd", 64'(rd_ready), 64'((k < WR_STARVE_MAX) || (k == 11)));
      check_eq("starve_wr", 64'(wr_ready), 64'(k == WR_STARVE_MAX + 1));
      if (rd_ready) r++;
      tick();
    end
    rd_valid = 1'b0;
    wr_valid = 1'b0;
    drain();

    // Reset while reads are in flight
    rd_valid = 1'b1;
    rd_addr  = 20'h00010;
    #1;
    check_eq("mid_rd0", 64'(rd_ready), 64'd1);
    tick();
    rd_addr = 20'h00011;
    #1;
    check_eq("mid_rd1", 64'(rd_ready), 64'd1);
    tick();
    rd_addr = 20'h00012;
    reset   = 1'b1;
    #1;
    check_eq("mid_rst_rdy", 64'(rd_ready), 64'd0);
    tick();
    reset    = 1'b0;
    rd_valid = 1'b0;
    wr_valid = 1'b1;
    wr_addr  = 20'h00040;
    wr_data  = 16'h0F0F;
    #1;
    check_eq("post_rst_wr", 64'(wr_ready), 64'd1);
    tick();
    wr_valid = 1'b0;
    repeat (8) begin
      #1;
      check_eq("post_rst_resp", 64'(rd_resp_valid), 64'd0);
      tick();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks made", n_chk);
    $fatal(1);
  end

endmodule

// File: doc/sram_frame_arbiter.md
Name: sram_frame_arbiter

Overview:
- Sits directly upstream of the SRAM wrapper and is the only master of its wen/addr/din/dout interface.
- Arbitrates between two streams: a pixel write stream from the capture/tracking path and a read-request stream from the display path.
- Inserts a bus-turnaround cycle whenever the transfer direction changes.
- Tracks the wrapper's fixed read latency and returns read data with a valid strobe.

Parameters:
- ADDR_W, 20, SRAM word address width.
- DATA_W, 16, SRAM word width.
- RD_LAT, 2, cycles from issuing a read on sram_addr to valid data on sram_dout.
- WR_STARVE_MAX, 8, consecutive cycles a pending write may lose to reads before it is forced through.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- wr_valid  in  1  write request present.
- wr_ready  out  1  write accepted this cycle.
- wr_addr  in  ADDR_W  write word address.
- wr_data  in  DATA_W  write data.
- rd_valid  in  1  read request present.
- rd_ready  out  1  read request accepted this cycle.
- rd_addr  in  ADDR_W  read word address.
- rd_resp_valid  out  1  read data valid strobe.
- rd_resp_data  out  DATA_W  read data.
- sram_wen  out  1  to wrapper wen; 1 = write.
- sram_addr  out  ADDR_W  to wrapper addr.
- sram_din  out  DATA_W  to wrapper din.
- sram_dout  in  DATA_W  from wrapper dout.

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on the clk rising edge.
  - reset (synchronous, active-high) clears state to IDLE and clears last_dir to READ, starve_cnt, and the latency pipe.
  - Output reset values: wr_ready=0, rd_ready=0, rd_resp_valid=0, rd_resp_data=0, sram_wen=0, sram_addr=0, sram_din=0.
- Handshakes:
  - A transfer occurs when valid && ready in the same cycle.
  - ready is a combinational grant from the current state and the inputs.
  - Requesters hold addr/data stable while valid && !ready.
- Issue timing:
  - sram_wen, sram_addr and sram_din are registered and present the granted transfer in the cycle after acceptance.
  - In cycles with no grant: sram_wen=0, sram_addr holds its last value, sram_din holds its last value.
- State machine states: IDLE, RD, WR, TURN.
  - Grant rule: a read wins over a write unless starve_cnt == WR_STARVE_MAX. In that case the write wins.
  - If the winner's direction differs from last_dir and the previous cycle issued a transfer, go to TURN for one cycle with no grant. Grant on the following cycle.
  - A direction change after at least one idle cycle needs no TURN, because IDLE already provides the gap.
  - RD/WR: remain in that state while the same direction keeps winning, granting one transfer per cycle. Back-to-back same-direction throughput is 1 transfer per clk.
  - If nothing is pending, go to IDLE.
  - last_dir updates on every grant.
- Write starvation:
  - starve_cnt increments (saturating at WR_STARVE_MAX) in each cycle where wr_valid=1 and no write is granted.
  - starve_cnt clears to 0 on any write grant, or when wr_valid=0.
- Read latency:
  - The read-tag shift register is RD_LAT+1 deep. A 1 is shifted in on a read grant; 0 otherwise.
  - When the tail is 1: rd_resp_valid=1 and rd_resp_data is captured from sram_dout.
  - Total latency from read acceptance (rd_valid && rd_ready at edge N) to rd_resp_valid high is RD_LAT+1 cycles, i.e. the response is visible after edge N+RD_LAT+1.
  - Responses return in request order. There is no back-pressure on responses; the consumer must always accept.
  - rd_resp_data holds its last value when rd_resp_valid=0.
- Simultaneous events:
  - rd_valid and wr_valid together with starve_cnt < max: read granted; wr_ready=0.
  - Never grant both ports in one cycle.
- Reset mid-operation: in-flight read tags are dropped; no rd_resp_valid for requests accepted before reset.
- Address and data pass through unmodified; no wrap-around or arithmetic on addresses.

Decomposition:
- Shared package sram_pkg:
  - ADDR_W, DATA_W and RD_LAT defaults.
  - State enum constants for IDLE/RD/WR/TURN.
  - Direction constants DIR_RD, DIR_WR.
- Sub-module sram_rd_latency_pipe: the parameterised tag shift register plus the response data capture register.

Test Plan:
- Reset check: assert reset for 3 cycles with wr_valid=rd_valid=1 -> all outputs 0; no ready asserted while reset=1.
- Single write then single read: write addr 0x00010 data 0xBEEF; after one idle cycle, read 0x00010 -> sram_wen=1 with addr 0x00010 and din 0xBEEF one cycle after accept; rd_resp_valid high exactly RD_LAT+1 cycles after read accept, with wrapper model data 0xBEEF.
- Back-to-back reads: 16 consecutive reads, addresses 0..15 -> rd_ready=1 every cycle; 16 responses in order, contiguous, starting RD_LAT+1 cycles after the first accept.
- Direction turnaround: write accepted at cycle N, read pending at N+1 -> TURN at N+1 (rd_ready=0); read granted at N+2; sram_wen=0 on the read issue cycle.
- Write starvation: rd_valid held high continuously, wr_valid high from cycle 0 -> write granted after exactly WR_STARVE_MAX=8 losing cycles (plus TURN); reads then resume after a TURN.
- Reset mid-read: 2 reads accepted, reset asserted the next cycle for 1 cycle -> no rd_resp_valid pulses afterwards; state returns to IDLE.
